clk_div_gen: RTL
================

// Module: clk_div_gen
// PURPOSE
//  Parametrised multi-channel clock divider/strobe generator in the CLKIN domain (behind the DCM/BUFG clock tree).
//  Feeds ADC encode, ADC serial and SPI timing. N channels, each with a runtime divide ratio, glitch-free
//  50%-ish clock, one-cycle enable strobe, common SYNC realignment and a LOCKED settle indicator.
// PARAMETERS
//  N_CH         3    number of output channels (1..16)
//  DIV_W        8    divide-ratio / counter width (2..16)
//  DEFAULT_DIV  4    divide ratio of every channel after reset (2..2^DIV_W-1)
//  LOCK_CYCLES  16   CLKIN cycles from reset release or SYNC until LOCKED=1 (>=1)
// PORTS
//  CLKIN      in   1                   single clock; all logic on its rising edge
//  RST_N      in   1                   asynchronous, active-low reset
//  CH_EN      in   N_CH                per-channel run enable
//  SYNC       in   1                   one-cycle pulse: realign all channels, restart settle
//  CFG_WE     in   1                   write strobe for the divide-ratio shadow register
//  CFG_ADDR   in   $clog2(N_CH) (min 1) channel select; values >= N_CH are ignored
//  CFG_DATA   in   DIV_W               new divide ratio
//  CFG_PHASE  in   DIV_W               phase offset (present only with CLK_DIV_GEN_PHASE_EN)
//  CLK_OUT    out  N_CH                divided clocks, flip-flop outputs
//  CLK_EN     out  N_CH                one-cycle strobe coincident with each CLK_OUT rising edge
//  LOCKED     out  1                   outputs settled
// BEHAVIOUR
//  - Reset: CLK_OUT=0, CLK_EN=0, LOCKED=0, shadow=active=DEFAULT_DIV, cnt=DEFAULT_DIV-1, FSM=SETTLE, settle cnt=0.
//  - Per channel: active ratio d, counter cnt in 0..d-1. Each edge cnt<=(cnt==d-1)?0:cnt+1.
//  - CLK_OUT/CLK_EN are registered from next-state cnt: CLK_OUT=(cnt<ceil(d/2)), CLK_EN=(cnt==0). Hence first edge
//    after reset release gives cnt=0, CLK_OUT=1, CLK_EN=1 on all enabled channels. Odd d: high ceil(d/2), low floor.
//  - CFG_WE writes shadow[CFG_ADDR]; CFG_DATA 0 or 1 stored as 2. Shadow copied to active only at wrap
//    (cnt==d-1), at SYNC, or while channel disabled: never mid-period, so no runt pulses.
//  - CH_EN[i]=0 sampled: cnt<=d-1, CLK_OUT=0, CLK_EN=0, active<=shadow. Re-enable: next edge cnt=0, CLK_EN=1.
//  - SYNC sampled: every enabled channel loads active<=shadow, cnt<=0 (or phase); CLK_EN of all channels with
//    phase 0 asserts in the same registered cycle.
//  - CFG_WE and SYNC same edge: write goes through, SYNC uses the new value. CFG_WE and wrap same edge: new
//    value becomes active at that wrap.
//  - FSM SETTLE->LOCKED: SETTLE counts edges; at count LOCK_CYCLES-1 -> LOCKED, LOCKED=1 on the following
//    edge (exactly LOCK_CYCLES edges after reset release). SYNC in any state -> SETTLE, count=0, LOCKED=0
//    at that edge. CFG_WE and CH_EN do not affect LOCKED.
//  - RST_N low mid-operation: all state cleared asynchronously to reset values, shadow writes lost.
// CONFIGURATION
//  CLK_DIV_GEN_PHASE_EN defined: CFG_PHASE port exists; CFG_WE also stores phase[CFG_ADDR] (value >= d clamped
//    to d-1); SYNC loads cnt<=phase, so first CLK_EN comes (d-phase) mod d edges after SYNC.
//  Undefined: no CFG_PHASE port, no phase storage; SYNC always loads cnt<=0.
// STRUCTURE
//  clk_div_gen_pkg: FSM state encoding (ST_SETTLE, ST_LOCKED), MIN_DIV=2 constant, width helper for
//    settle counter ($clog2(LOCK_CYCLES+1)).
//  Sub-module clk_div_chan: one channel (shadow, active, cnt, phase, output regs); top = N_CH generate
//    instances + write decode + lock FSM.
// TESTING
//  1. N_CH=3, defaults, release reset -> each CLK_OUT 1,1,0,0 repeating; CLK_EN every 4th edge from edge 1; LOCKED=1 exactly 16 edges after release.
//  2. Write ch1 ratio 5 mid-period -> current period finishes at 4; then high 3, low 2, CLK_EN every 5 edges.
//  3. Write ch0 ratio 0 and then 1 -> ch0 toggles each edge (ratio 2), CLK_EN every 2nd edge.
//  4. SYNC with simultaneous write ch2 ratio 6 -> all CLK_EN=1 on SYNC edge, ch2 period 6, LOCKED low 16 edges then high.
//  5. CH_EN[1]=0 while CLK_OUT[1]=1 -> CLK_OUT[1]=0 next edge and stays; CH_EN[1]=1 -> CLK_EN[1]=1 next edge.
//  6. With CLK_DIV_GEN_PHASE_EN: ch0 ratio 4 phase 2, SYNC -> ch0 first CLK_EN 2 edges after SYNC; phase 7 -> clamped 3.

Source files
------------

// File: rtl/clk_div_gen_pkg.sv
// Shared types and constants for the clk_div_gen clock divider / strobe generator.
// Optional phase offset support is selected with the CLK_DIV_GEN_PHASE_EN macro.
package clk_div_gen_pkg;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Smallest divide ratio that still yields a real high and low phase.
    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned settle_cnt_w(input int unsigned lock_cycles);
        return (lock_cycles < 1) ? 1 : $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active ratio, period counter and registered clock/strobe.
// With CLK_DIV_GEN_PHASE_EN defined, a per-channel phase offset is loaded on SYNC.
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [DIV_W-1:0] wr_div,
`ifdef CLK_DIV_GEN_PHASE_EN
    input  logic [DIV_W-1:0] wr_phase,
`endif
    output logic             clk_out,
    output logic             clk_en
);

    localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] shadow, active, cnt;
    logic [DIV_W-1:0] shadow_n, active_n, cnt_n;
    logic [DIV_W-1:0] wr_div_s;
    logic [DIV_W-1:0] half_n;
    logic [DIV_W-1:0] sync_cnt;

`ifdef CLK_DIV_GEN_PHASE_EN
    logic [DIV_W-1:0] phase, phase_n;
`endif

    always_comb begin
        wr_div_s = (wr_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : wr_div;
        shadow_n = we ? wr_div_s : shadow;
`ifdef CLK_DIV_GEN_PHASE_EN
        phase_n  = phase;
        if (we) begin
            phase_n = (wr_phase >= wr_div_s) ? (wr_div_s - 1'b1) : wr_phase;
        end
        sync_cnt = phase_n;
`else
        sync_cnt = '0;
`endif
        // Ratio changes take effect only at a period boundary, so no runt pulses.
        active_n = active;
        cnt_n    = cnt + 1'b1;
        if (!en) begin
            active_n = shadow_n;
            cnt_n    = shadow_n - 1'b1;
        end else if (sync) begin
            active_n = shadow_n;
            cnt_n    = sync_cnt;
        end else if (cnt == active - 1'b1) begin
            active_n = shadow_n;
            cnt_n    = '0;
        end
        half_n = (active_n >> 1) + {{(DIV_W-1){1'b0}}, active_n[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= DEF_D;
            active  <= DEF_D;
            cnt     <= DEF_D - 1'b1;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
`ifdef CLK_DIV_GEN_PHASE_EN
            phase   <= '0;
`endif
        end else begin
            shadow  <= shadow_n;
            active  <= active_n;
            cnt     <= cnt_n;
            clk_out <= en && (cnt_n < half_n);
            clk_en  <= en && (cnt_n == '0);
`ifdef CLK_DIV_GEN_PHASE_EN
            phase   <= phase_n;
`endif
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider / strobe generator with common SYNC and LOCKED settle indicator.
// Define CLK_DIV_GEN_PHASE_EN to add the CFG_PHASE port and per-channel phase offsets.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic                                         CLKIN,
    input  logic                                         RST_N,
    input  logic [N_CH-1:0]                              CH_EN,
    input  logic                                         SYNC,
    input  logic                                         CFG_WE,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   CFG_ADDR,
    input  logic [DIV_W-1:0]                             CFG_DATA,
`ifdef CLK_DIV_GEN_PHASE_EN
    input  logic [DIV_W-1:0]                             CFG_PHASE,
`endif
    output logic [N_CH-1:0]                              CLK_OUT,
    output logic [N_CH-1:0]                              CLK_EN,
    output logic                                         LOCKED
);

    localparam int unsigned ADDR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned SC_W   = settle_cnt_w(LOCK_CYCLES);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(LOCK_CYCLES - 1);

    // Addresses >= N_CH match no instance, so such writes are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic we_ch;
        assign we_ch = CFG_WE && (CFG_ADDR == ADDR_W'(i));

        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (CLKIN),
            .rst_n    (RST_N),
            .en       (CH_EN[i]),
            .sync     (SYNC),
            .we       (we_ch),
            .wr_div   (CFG_DATA),
`ifdef CLK_DIV_GEN_PHASE_EN
            .wr_phase (CFG_PHASE),
`endif
            .clk_out  (CLK_OUT[i]),
            .clk_en   (CLK_EN[i])
        );
    end

    lock_state_t     state;
    logic [SC_W-1:0] settle_cnt;

    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            LOCKED     <= 1'b0;
        end else if (SYNC) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            LOCKED     <= 1'b0;
        end else begin
            unique case (state)
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state  <= ST_LOCKED;
                        LOCKED <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    LOCKED <= 1'b1;
                end
            endcase
        end
    end

endmodule
